// File: rtl/tlb_op_sequencer.sv
// tlb_op_sequencer: runs TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB against a shared TLB.
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   op_valid/op_ready/op_code        committed TLB op handshake from WB (0 SRCH,1 RD,2 WR,3 FILL,4 INV)
//   inv_op, inv_asid, inv_vppn       INVTLB operands, latched on accept
//   op_pc                            PC of the op, latched on accept
//   csr_index, csr_vppn, csr_asid    live CSR fields (TLBIDX.index, TLBEHI.vppn, ASID.asid)
//   mem_req/mem_gnt                  MEM-stage request/grant for the s1 search port
//   s1_own, s1_vppn, s1_asid         s1 mux select and search key while this block owns s1
//   s1_found, s1_index               s1 search result (same cycle)
//   r_index, r_e, r_g, r_asid, r_vppn  TLB read port
//   tlb_we, tlb_w_index, tlb_w_clr   TLB write port (clr writes E=0, else CSR fields)
//   srch_vld, srch_hit, srch_idx     TLBSRCH result for CSR update
//   rd_vld                           TLBRD capture strobe
//   op_done, op_err                  completion pulse and illegal-op flag
//   reflush, reflush_pc              refetch request at op_pc+4
module tlb_op_sequencer #(
    parameter int TLBNUM = 16,
    parameter int IDX_W  = $clog2(TLBNUM)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [4:0]       inv_op,
    input  logic [9:0]       inv_asid,
    input  logic [18:0]      inv_vppn,
    input  logic [31:0]      op_pc,
    input  logic [IDX_W-1:0] csr_index,
    input  logic [18:0]      csr_vppn,
    input  logic [9:0]       csr_asid,
    input  logic             mem_req,
    output logic             mem_gnt,
    output logic             s1_own,
    output logic [18:0]      s1_vppn,
    output logic [9:0]       s1_asid,
    input  logic             s1_found,
    input  logic [IDX_W-1:0] s1_index,
    output logic [IDX_W-1:0] r_index,
    input  logic             r_e,
    input  logic             r_g,
    input  logic [9:0]       r_asid,
    input  logic [18:0]      r_vppn,
    output logic             tlb_we,
    output logic [IDX_W-1:0] tlb_w_index,
    output logic             tlb_w_clr,
    output logic             srch_vld,
    output logic             srch_hit,
    output logic [IDX_W-1:0] srch_idx,
    output logic             rd_vld,
    output logic             op_done,
    output logic             op_err,
    output logic             reflush,
    output logic [31:0]      reflush_pc
);
    typedef enum logic [2:0] {IDLE, SRCH, RD, WR, INV, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(TLBNUM - 1);

    state_t           state, state_nx;
    logic [2:0]       code_q;
    logic [4:0]       inv_op_q;
    logic [9:0]       inv_asid_q;
    logic [18:0]      inv_vppn_q;
    logic [31:0]      pc_q;
    logic             err_q;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] fill_cnt;
    logic             srch_hit_q;
    logic [IDX_W-1:0] srch_idx_q;
    logic             accept;
    logic             bad_op;
    logic             asid_eq;
    logic             vppn_eq;
    logic             inv_sel;
    logic             inv_match;

    assign accept  = op_valid & op_ready;
    // Illegal codes and out-of-range INVTLB ops share one idle pass through INV so
    // that their completion lands at the same latency as the short ops.
    assign bad_op  = (op_code > 3'd4) || (op_code == 3'd4 && inv_op > 5'd6);
    assign asid_eq = r_asid == inv_asid_q;
    assign vppn_eq = r_vppn == inv_vppn_q;
    assign mem_gnt = mem_req & ~s1_own;

    always_comb begin
        inv_sel = 1'b0;
        case (inv_op_q)
            5'd0, 5'd1: inv_sel = 1'b1;
            5'd2:       inv_sel = r_g;
            5'd3:       inv_sel = ~r_g;
            5'd4:       inv_sel = ~r_g & asid_eq;
            5'd5:       inv_sel = ~r_g & asid_eq & vppn_eq;
            5'd6:       inv_sel = (r_g | asid_eq) & vppn_eq;
            default:    inv_sel = 1'b0;
        endcase
    end

    assign inv_match = r_e & inv_sel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        op_ready    = 1'b0;
        s1_own      = 1'b0;
        s1_vppn     = '0;
        s1_asid     = '0;
        r_index     = '0;
        tlb_we      = 1'b0;
        tlb_w_index = '0;
        tlb_w_clr   = 1'b0;
        srch_vld    = 1'b0;
        srch_hit    = srch_hit_q;
        srch_idx    = srch_idx_q;
        rd_vld      = 1'b0;
        op_done     = 1'b0;
        op_err      = 1'b0;
        reflush     = 1'b0;
        reflush_pc  = '0;
        case (state)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid)
                    state_nx = bad_op ? INV :
                               op_code == 3'd0 ? SRCH :
                               op_code == 3'd1 ? RD :
                               op_code == 3'd4 ? INV : WR;
            end
            SRCH: begin
                s1_own   = 1'b1;
                s1_vppn  = csr_vppn;
                s1_asid  = csr_asid;
                srch_vld = 1'b1;
                srch_hit = s1_found;
                srch_idx = s1_index;
                state_nx = DONE;
            end
            RD: begin
                r_index  = csr_index;
                rd_vld   = 1'b1;
                state_nx = DONE;
            end
            WR: begin
                tlb_we      = 1'b1;
                tlb_w_index = code_q == 3'd3 ? fill_cnt : csr_index;
                state_nx    = DONE;
            end
            INV: begin
                if (!err_q) begin
                    r_index     = cnt;
                    tlb_we      = inv_match;
                    tlb_w_clr   = inv_match;
                    tlb_w_index = cnt;
                end
                if (err_q || cnt == LAST)
                    state_nx = DONE;
            end
            DONE: begin
                op_done    = 1'b1;
                op_err     = err_q;
                reflush    = code_q != 3'd0;
                reflush_pc = code_q != 3'd0 ? pc_q + 32'd4 : '0;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            code_q     <= '0;
            inv_op_q   <= '0;
            inv_asid_q <= '0;
            inv_vppn_q <= '0;
            pc_q       <= '0;
            err_q      <= 1'b0;
            cnt        <= '0;
            fill_cnt   <= '0;
            srch_hit_q <= 1'b0;
            srch_idx_q <= '0;
        end else begin
            fill_cnt <= fill_cnt == LAST ? '0 : fill_cnt + IDX_W'(1);
            if (accept) begin
                code_q     <= op_code;
                inv_op_q   <= inv_op;
                inv_asid_q <= inv_asid;
                inv_vppn_q <= inv_vppn;
                pc_q       <= op_pc;
                err_q      <= bad_op;
                cnt        <= '0;
            end else if (state == INV) begin
                cnt <= cnt + IDX_W'(1);
            end
            if (state == SRCH) begin
                srch_hit_q <= s1_found;
                srch_idx_q <= s1_index;
            end
        end
    end
endmodule

// File: tb/tb_tlb_op_sequencer.sv
// tb_tlb_op_sequencer: randomized and directed checks of tlb_op_sequencer against a TLB-level model.
module tb_tlb_op_sequencer;
    localparam int N = 16;

    typedef struct packed {
        logic        e;
        logic        g;
        logic [9:0]  asid;
        logic [18:0] vppn;
    } ent_t;

    logic        clk = 1'b0, resetn = 1'b0;
    logic        op_valid = 1'b0, op_ready;
    logic [2:0]  op_code = '0;
    logic [4:0]  inv_op = '0;
    logic [9:0]  inv_asid = '0;
    logic [18:0] inv_vppn = '0;
    logic [31:0] op_pc = '0;
    logic [3:0]  csr_index = '0;
    logic [18:0] csr_vppn = '0;
    logic [9:0]  csr_asid = '0;
    logic        mem_req = 1'b0, mem_gnt, s1_own;
    logic [18:0] s1_vppn;
    logic [9:0]  s1_asid;
    logic        s1_found;
    logic [3:0]  s1_index;
    logic [3:0]  r_index;
    logic        r_e, r_g;
    logic [9:0]  r_asid;
    logic [18:0] r_vppn;
    logic        tlb_we, tlb_w_clr;
    logic [3:0]  tlb_w_index;
    logic        srch_vld, srch_hit;
    logic [3:0]  srch_idx;
    logic        rd_vld, op_done, op_err, reflush;
    logic [31:0] reflush_pc;

    ent_t        tlb [N] = '{default: '0};
    ent_t        exp_t [N];
    logic        ld = 1'b0;
    logic [3:0]  ld_idx = '0;
    ent_t        ld_val = '0;
    logic        cg = 1'b0;
    int          fc;
    int          pass_n = 0, total = 0, viol = 0;

    int          lat, rd_n, sv_n, fc1;
    logic [4:0]  wq [$];
    logic [4:0]  e_wq [$];
    logic [3:0]  rd_idx, si, di, e_si;
    logic        sh, dh, err, rf, own1, gnt1, gnt_d, rdy_after, done_after;
    logic        e_err, e_rf, e_sh;
    int          e_lat;
    logic [31:0] rpc;

    always #5 clk = ~clk;

    tlb_op_sequencer dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn), .op_pc(op_pc),
        .csr_index(csr_index), .csr_vppn(csr_vppn), .csr_asid(csr_asid),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .s1_own(s1_own), .s1_vppn(s1_vppn), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index), .r_index(r_index), .r_e(r_e), .r_g(r_g),
        .r_asid(r_asid), .r_vppn(r_vppn), .tlb_we(tlb_we), .tlb_w_index(tlb_w_index),
        .tlb_w_clr(tlb_w_clr), .srch_vld(srch_vld), .srch_hit(srch_hit), .srch_idx(srch_idx),
        .rd_vld(rd_vld), .op_done(op_done), .op_err(op_err), .reflush(reflush), .reflush_pc(reflush_pc)
    );

    // TLB environment: combinational read/search, writes on the clock edge.
    assign {r_e, r_g, r_asid, r_vppn} = tlb[r_index];

    always_comb begin
        s1_found = 1'b0;
        s1_index = '0;
        for (int i = N - 1; i >= 0; i--)
            if (tlb[i].e && tlb[i].vppn == s1_vppn && (tlb[i].g || tlb[i].asid == s1_asid)) begin
                s1_found = 1'b1;
                s1_index = 4'(i);
            end
    end

    always @(posedge clk) begin
        if (ld)
            tlb[ld_idx] <= ld_val;
        else if (resetn && tlb_we)
            tlb[tlb_w_index] <= tlb_w_clr ? {1'b0, tlb[tlb_w_index][29:0]} : {1'b1, cg, csr_asid, csr_vppn};
    end

    // Edges seen since reset: the free-running fill index is this count mod N.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) fc <= 0;
        else fc <= fc + 1;
    end

    function automatic ent_t rnd_ent();
        ent_t v;
        v.e    = $urandom_range(0, 3) != 0;
        v.g    = 1'($urandom);
        v.asid = $urandom_range(0, 1) ? 10'h12 : 10'h34;
        v.vppn = $urandom_range(0, 1) ? 19'h400 : 19'h401;
        return v;
    endfunction

    function automatic logic inv_hit(ent_t t, int op, logic [9:0] a, logic [18:0] v);
        logic am, vm;
        am = t.asid == a;
        vm = t.vppn == v;
        if (!t.e) return 1'b0;
        case (op)
            0, 1: return 1'b1;
            2: return t.g;
            3: return !t.g;
            4: return !t.g && am;
            5: return !t.g && am && vm;
            6: return (t.g || am) && vm;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int tlb_diff();
        for (int i = 0; i < N; i++) if (tlb[i] !== exp_t[i]) return i;
        return -1;
    endfunction

    function automatic logic wq_diff();
        if (wq.size() != e_wq.size()) return 1'b1;
        foreach (e_wq[i]) if (wq[i] !== e_wq[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic sync_tlb();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            ld = 1'b1;
            ld_idx = 4'(i);
            ld_val = exp_t[i];
        end
        @(negedge clk);
        ld = 1'b0;
    endtask

    // Drives one op, records what the DUT did, then applies the model's view of the op.
    task automatic run_op(input logic [2:0] c, input logic [4:0] io, input logic [9:0] ia,
                          input logic [18:0] iv, input logic [31:0] pc, input logic [3:0] ci,
                          input logic [18:0] cv, input logic [9:0] ca, input logic g, input logic mr);
        logic bad;
        logic [3:0] widx;
        @(negedge clk);
        op_valid = 1'b1; op_code = c; inv_op = io; inv_asid = ia; inv_vppn = iv; op_pc = pc;
        csr_index = ci; csr_vppn = cv; csr_asid = ca; cg = g; mem_req = mr;
        wq.delete(); rd_n = 0; sv_n = 0; lat = 0; own1 = 0; gnt1 = 0; gnt_d = 0;
        sh = 0; si = 0; dh = 0; di = 0; err = 0; rf = 0; rpc = 0; rd_idx = 0; fc1 = 0;
        @(posedge clk);
        #1;
        op_valid = 1'b0; op_code = 3'($urandom); inv_op = 5'($urandom);
        inv_asid = 10'($urandom); inv_vppn = 19'($urandom); op_pc = $urandom;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            lat = k;
            if (k == 1) begin own1 = s1_own; gnt1 = mem_gnt; fc1 = fc; end
            if (tlb_we) wq.push_back({tlb_w_clr, tlb_w_index});
            if (rd_vld) begin rd_n++; rd_idx = r_index; end
            if (srch_vld) begin sv_n++; sh = srch_hit; si = srch_idx; end
            if (tlb_we && rd_vld) viol++;
            if (op_ready) viol++;
            if (s1_own !== (c == 3'd0 && k == 1)) viol++;
            if (mem_gnt !== (mr && !(c == 3'd0 && k == 1))) viol++;
            if (op_done) begin
                err = op_err; rf = reflush; rpc = reflush_pc; dh = srch_hit; di = srch_idx; gnt_d = mem_gnt;
                break;
            end
            if (reflush || op_err) viol++;
        end
        @(negedge clk);
        rdy_after = op_ready;
        done_after = op_done;
        bad = c > 3'd4 || (c == 3'd4 && io > 5'd6);
        e_err = bad;
        e_rf = c != 3'd0;
        e_lat = (c == 3'd4 && !bad) ? N + 1 : 2;
        e_wq.delete();
        e_sh = 1'b0;
        e_si = '0;
        if (c == 3'd0)
            for (int i = N - 1; i >= 0; i--)
                if (exp_t[i].e && exp_t[i].vppn == cv && (exp_t[i].g || exp_t[i].asid == ca)) begin
                    e_sh = 1'b1;
                    e_si = 4'(i);
                end
        if (c == 3'd2 || c == 3'd3) begin
            widx = c == 3'd3 ? 4'(fc1 % N) : ci;
            e_wq.push_back({1'b0, widx});
            exp_t[widx] = {1'b1, g, ca, cv};
        end
        if (c == 3'd4 && !bad)
            for (int i = 0; i < N; i++)
                if (inv_hit(exp_t[i], int'(io), ia, iv)) begin
                    e_wq.push_back({1'b1, 4'(i)});
                    exp_t[i].e = 1'b0;
                end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (op_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", op_ready); else pass_n++;
        total++; if (tlb_we !== 1'b0) $display("FAIL reset_we: got %b want 0", tlb_we); else pass_n++;
        total++; if (op_done !== 1'b0) $display("FAIL reset_done: got %b want 0", op_done); else pass_n++;
        total++; if (reflush !== 1'b0) $display("FAIL reset_reflush: got %b want 0", reflush); else pass_n++;
        total++; if (s1_own !== 1'b0) $display("FAIL reset_own: got %b want 0", s1_own); else pass_n++;
        total++; if (srch_hit !== 1'b0) $display("FAIL reset_hit: got %b want 0", srch_hit); else pass_n++;
        total++; if (rd_vld !== 1'b0) $display("FAIL reset_rdvld: got %b want 0", rd_vld); else pass_n++;
        resetn = 1'b1;
        for (int i = 0; i < N; i++) exp_t[i] = '0;
    endtask

    task automatic test_srch_arb();
        for (int i = 0; i < N; i++) exp_t[i] = {1'b1, 1'b0, 10'h34, 19'h7};
        exp_t[5] = {1'b1, 1'b0, 10'h12, 19'h400};
        sync_tlb();
        run_op(3'd0, 5'd0, 10'h0, 19'h0, 32'h1c000200, 4'd0, 19'h400, 10'h12, 1'b0, 1'b1);
        total++; if (own1 !== 1'b1) $display("FAIL srch_own: got %b want 1", own1); else pass_n++;
        total++; if (gnt1 !== 1'b0) $display("FAIL srch_gnt_t1: got %b want 0", gnt1); else pass_n++;
        total++; if (sv_n !== 1) $display("FAIL srch_vld_count: got %0d want 1", sv_n); else pass_n++;
        total++; if ({sh, si} !== {1'b1, 4'd5}) $display("FAIL srch_result: got hit=%b idx=%0d want hit=1 idx=5", sh, si); else pass_n++;
        total++; if ({dh, di} !== {1'b1, 4'd5}) $display("FAIL srch_held: got hit=%b idx=%0d want hit=1 idx=5", dh, di); else pass_n++;
        total++; if (lat !== 2) $display("FAIL srch_lat: got %0d want 2", lat); else pass_n++;
        total++; if (gnt_d !== 1'b1) $display("FAIL srch_gnt_t2: got %b want 1", gnt_d); else pass_n++;
        total++; if (rf !== 1'b0) $display("FAIL srch_reflush: got %b want 0", rf); else pass_n++;
        total++; if (rdy_after !== 1'b1 || done_after !== 1'b0) $display("FAIL srch_after: got ready=%b done=%b want 1 0", rdy_after, done_after); else pass_n++;
        mem_req = 1'b0;
    endtask

    task automatic test_rd();
        run_op(3'd1, 5'd0, 10'h0, 19'h0, 32'h1c000100, 4'd9, 19'h0, 10'h0, 1'b0, 1'b0);
        total++; if (rd_n !== 1 || rd_idx !== 4'd9) $display("FAIL rd_strobe: got n=%0d idx=%0d want n=1 idx=9", rd_n, rd_idx); else pass_n++;
        total++; if (lat !== 2) $display("FAIL rd_lat: got %0d want 2", lat); else pass_n++;
        total++; if (rf !== 1'b1) $display("FAIL rd_reflush: got %b want 1", rf); else pass_n++;
        total++; if (rpc !== 32'h1c000104) $display("FAIL rd_pc: got %h want 1c000104", rpc); else pass_n++;
        total++; if (wq.size() !== 0) $display("FAIL rd_nowrite: got %0d writes want 0", wq.size()); else pass_n++;
    endtask

    task automatic test_wr_fill();
        run_op(3'd2, 5'd0, 10'h0, 19'h0, 32'h100, 4'd3, 19'h1234, 10'h56, 1'b1, 1'b0);
        total++; if (wq.size() !== 1 || wq[0] !== 5'h03) $display("FAIL wr_write: got n=%0d first=%h want n=1 03", wq.size(), wq.size() > 0 ? wq[0] : 5'h1f); else pass_n++;
        for (int r = 0; r < 2; r++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_op(3'd3, 5'd0, 10'h0, 19'h0, 32'h200, 4'd0, 19'h2000 + 19'(r), 10'h77, 1'b0, 1'b0);
            total++; if (wq_diff()) $display("FAIL fill_index: got n=%0d first=%h want %h", wq.size(), wq.size() > 0 ? wq[0] : 5'h1f, e_wq[0]); else pass_n++;
        end
        total++; if (tlb_diff() !== -1) $display("FAIL wr_tlb: got mismatch at entry %0d want none", tlb_diff()); else pass_n++;
    endtask

    task automatic test_inv();
        for (int i = 0; i < N; i++) exp_t[i] = {1'b1, 1'b0, 10'h34, 19'h400};
        exp_t[2]  = {1'b1, 1'b0, 10'h12, 19'h400};
        exp_t[7]  = {1'b1, 1'b0, 10'h12, 19'h400};
        exp_t[11] = {1'b1, 1'b1, 10'h12, 19'h400};
        sync_tlb();
        run_op(3'd4, 5'd5, 10'h12, 19'h400, 32'h300, 4'd0, 19'h0, 10'h0, 1'b0, 1'b0);
        total++; if (wq.size() !== 2 || wq[0] !== 5'h12 || wq[1] !== 5'h17) $display("FAIL inv_writes: got n=%0d want clears of 2 and 7", wq.size()); else pass_n++;
        total++; if (lat !== 17) $display("FAIL inv_lat: got %0d want 17", lat); else pass_n++;
        total++; if (tlb_diff() !== -1) $display("FAIL inv_tlb: got mismatch at entry %0d want none", tlb_diff()); else pass_n++;
    endtask

    task automatic test_err();
        run_op(3'd4, 5'd7, 10'h12, 19'h400, 32'h400, 4'd0, 19'h0, 10'h0, 1'b0, 1'b1);
        total++; if ({err, lat} !== {1'b1, 32'd2}) $display("FAIL inv7_err: got err=%b lat=%0d want 1 2", err, lat); else pass_n++;
        total++; if (wq.size() !== 0) $display("FAIL inv7_nowrite: got %0d writes want 0", wq.size()); else pass_n++;
        total++; if (rf !== 1'b1 || rpc !== 32'h404) $display("FAIL inv7_reflush: got %b %h want 1 404", rf, rpc); else pass_n++;
        run_op(3'd6, 5'd0, 10'h0, 19'h0, 32'hfffffffc, 4'd1, 19'h0, 10'h0, 1'b0, 1'b1);
        total++; if ({err, lat} !== {1'b1, 32'd2}) $display("FAIL code6_err: got err=%b lat=%0d want 1 2", err, lat); else pass_n++;
        total++; if (wq.size() !== 0 || rd_n !== 0 || sv_n !== 0) $display("FAIL code6_quiet: got we=%0d rd=%0d srch=%0d want 0 0 0", wq.size(), rd_n, sv_n); else pass_n++;
        total++; if (rf !== 1'b1 || rpc !== 32'h0) $display("FAIL code6_reflush: got %b %h want 1 0", rf, rpc); else pass_n++;
        mem_req = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0] c;
        logic [4:0] io;
        logic [31:0] pc;
        for (int n = 0; n < 40; n++) begin
            if (n % 5 == 0) begin
                for (int i = 0; i < N; i++) exp_t[i] = rnd_ent();
                sync_tlb();
            end
            c = 3'($urandom_range(0, 7));
            io = 5'($urandom_range(0, 9));
            pc = $urandom_range(0, 7) == 0 ? 32'hfffffffc : $urandom;
            run_op(c, io, $urandom_range(0, 1) ? 10'h12 : 10'h34, $urandom_range(0, 1) ? 19'h400 : 19'h401,
                   pc, 4'($urandom), $urandom_range(0, 1) ? 19'h400 : 19'h401,
                   $urandom_range(0, 1) ? 10'h12 : 10'h34, 1'($urandom), 1'($urandom));
            total++; if (lat !== e_lat) $display("FAIL rand_lat op=%0d: got %0d want %0d", c, lat, e_lat); else pass_n++;
            total++; if (err !== e_err) $display("FAIL rand_err op=%0d: got %b want %b", c, err, e_err); else pass_n++;
            total++; if (rf !== e_rf) $display("FAIL rand_reflush op=%0d: got %b want %b", c, rf, e_rf); else pass_n++;
            if (e_rf) begin
                total++; if (rpc !== pc + 32'd4) $display("FAIL rand_pc: got %h want %h", rpc, pc + 32'd4); else pass_n++;
            end
            total++; if (wq_diff()) $display("FAIL rand_writes op=%0d inv=%0d: got %0d writes want %0d", c, io, wq.size(), e_wq.size()); else pass_n++;
            total++; if (rd_n !== int'(c == 3'd1)) $display("FAIL rand_rdvld op=%0d: got %0d want %0d", c, rd_n, int'(c == 3'd1)); else pass_n++;
            if (c == 3'd0) begin
                total++; if ({sh, si, dh, di} !== {e_sh, e_si, e_sh, e_si}) $display("FAIL rand_srch: got %b/%0d held %b/%0d want %b/%0d", sh, si, dh, di, e_sh, e_si); else pass_n++;
            end
            total++; if (tlb_diff() !== -1) $display("FAIL rand_tlb op=%0d: got mismatch at entry %0d want none", c, tlb_diff()); else pass_n++;
            total++; if (rdy_after !== 1'b1 || done_after !== 1'b0) $display("FAIL rand_after: got ready=%b done=%b want 1 0", rdy_after, done_after); else pass_n++;
        end
        mem_req = 1'b0;
    endtask

    task automatic test_reset_mid_inv();
        int nwe;
        for (int i = 0; i < N; i++) exp_t[i] = {1'b1, 1'($urandom), 10'h12, 19'h400};
        sync_tlb();
        @(negedge clk);
        op_valid = 1'b1; op_code = 3'd4; inv_op = 5'd0;
        @(posedge clk);
        #1 op_valid = 1'b0;
        repeat (9) @(negedge clk);
        total++; if (r_index !== 4'd8) $display("FAIL mid_cnt: got %0d want 8", r_index); else pass_n++;
        resetn = 1'b0;
        #1;
        total++; if (tlb_we !== 1'b0) $display("FAIL mid_we: got %b want 0", tlb_we); else pass_n++;
        total++; if (op_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", op_ready); else pass_n++;
        for (int i = 0; i < 8; i++) exp_t[i].e = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        nwe = 0;
        repeat (20) begin
            @(negedge clk);
            if (tlb_we || op_done) nwe++;
        end
        total++; if (nwe !== 0) $display("FAIL mid_quiet: got %0d active cycles want 0", nwe); else pass_n++;
        total++; if (tlb_diff() !== -1) $display("FAIL mid_tlb: got mismatch at entry %0d want none", tlb_diff()); else pass_n++;
    endtask

    initial begin
        test_reset();
        test_srch_arb();
        test_rd();
        test_wr_fill();
        test_inv();
        test_err();
        test_random();
        test_reset_mid_inv();
        total++; if (viol !== 0) $display("FAIL invariants: got %0d violations want 0", viol); else pass_n++;
        $display("%0d/%0d checks passed", pass_n, total);
        $finish;
    end
endmodule
